edge_detection_array_seq: RTL and testbench

Parametrised, time-multiplexed successor to the 5x5 edge-detection core. It captures a WIN_H x WIN_W pixel window on a start strobe and runs a single pipelined Sobel engine over every 3x3 sub-window in row-major order. It produces (WIN_H-2)*(WIN_W-2) gradient results, in either saturated-magnitude mode or thresholded binary mode. It sits between the window buffer and the output writer, and replaces the nine parallel Sobel instances with one shared engine.

---
 rtl/edge_detection_array_seq.sv | 176 +++++++++++++++++
 tb/tb_edge_detection_array_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detection_array_seq.sv
// Time-multiplexed Sobel edge detector. A WIN_H x WIN_W pixel window is
// captured on a start strobe. One shared two-stage Sobel engine then walks
// every 3x3 sub-window in row-major order. The complete result set is
// published on o_sums together with a single-cycle ready pulse.
module edge_detection_array_seq #(
   parameter int PIX_W = 8,
   parameter int WIN_W = 5,
   parameter int WIN_H = 5
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  i_gradient_start,
   input  logic                                  i_mode,
   input  logic [PIX_W-1:0]                      i_threshold,
   input  logic [WIN_W*WIN_H*PIX_W-1:0]          i_window,
   output logic                                  o_busy,
   output logic                                  o_gradient_ready,
   output logic [(WIN_W-2)*(WIN_H-2)*PIX_W-1:0]  o_sums
);

   localparam int OW       = WIN_W - 2;
   localparam int OH       = WIN_H - 2;
   localparam int NOUT     = OW * OH;
   localparam int IDX_W    = (NOUT > 1) ? $clog2(NOUT) : 1;
   localparam int MAG_W    = PIX_W + 4;
   localparam int G_W      = MAG_W + 1;
   localparam int WIN_BITS = WIN_W * WIN_H * PIX_W;
   localparam int OUT_BITS = NOUT * PIX_W;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOUT - 1);
   localparam logic [G_W-1:0]   SAT_MAX  = G_W'((1 << PIX_W) - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [WIN_BITS-1:0]     win_q, win_d;
   logic                    mode_q, mode_d;
   logic [PIX_W-1:0]        thr_q, thr_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic signed [G_W-1:0]   gx_q, gx_d;
   logic signed [G_W-1:0]   gy_q, gy_d;
   logic                    s1_valid_q, s1_valid_d;
   logic [IDX_W-1:0]        s1_idx_q, s1_idx_d;
   logic [OUT_BITS-1:0]     buf_q, buf_d;
   logic [OUT_BITS-1:0]     sums_q, sums_d;

   logic signed [G_W-1:0]   taps [NOUT][9];
   logic [G_W-1:0]          abs_x;
   logic [G_W-1:0]          abs_y;
   logic [G_W-1:0]          mag;
   logic [PIX_W-1:0]        result;

   // Every sub-window position gets its nine pixels wired out of the latched
   // window as zero-extended signed taps, so the engine only needs a mux on idx.
   for (genvar k = 0; k < NOUT; k++) begin : g_pos
      for (genvar j = 0; j < 9; j++) begin : g_tap
         localparam int BASE = (((k / OW) + (j / 3)) * WIN_W + (k % OW) + (j % 3)) * PIX_W;
         assign taps[k][j] = {{(G_W - PIX_W){1'b0}}, win_q[BASE +: PIX_W]};
      end
   end

   // Sequencing FSM: latch operands on start, issue one position per RUN
   // cycle, let the pipeline drain, then present results for one cycle.
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      mode_d     = mode_q;
      thr_d      = thr_q;
      idx_d      = idx_q;
      s1_valid_d = 1'b0;
      s1_idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (i_gradient_start) begin
               win_d   = i_window;
               mode_d  = i_mode;
               thr_d   = i_threshold;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            s1_valid_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = S_DRAIN;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Stage 1: horizontal and vertical Sobel gradients of the selected 3x3 window.
   always_comb begin
      gx_d = (taps[idx_q][2] + (taps[idx_q][5] <<< 1) + taps[idx_q][8])
           - (taps[idx_q][0] + (taps[idx_q][3] <<< 1) + taps[idx_q][6]);
      gy_d = (taps[idx_q][6] + (taps[idx_q][7] <<< 1) + taps[idx_q][8])
           - (taps[idx_q][0] + (taps[idx_q][1] <<< 1) + taps[idx_q][2]);
   end

   // Stage 2: L1 magnitude, then either saturate it or threshold it to a flag.
   always_comb begin
      abs_x = gx_q[G_W-1] ? -gx_q : gx_q;
      abs_y = gy_q[G_W-1] ? -gy_q : gy_q;
      mag   = abs_x + abs_y;
      if (mode_q) begin
         result = (mag >= {{(G_W - PIX_W){1'b0}}, thr_q}) ? '1 : '0;
      end else begin
         result = (mag > SAT_MAX) ? '1 : mag[PIX_W-1:0];
      end
   end

   // Each buffer slot takes the stage-2 result when its index comes out of the pipe.
   for (genvar k = 0; k < NOUT; k++) begin : g_buf
      assign buf_d[k*PIX_W +: PIX_W] =
         (s1_valid_q && (s1_idx_q == IDX_W'(k))) ? result : buf_q[k*PIX_W +: PIX_W];
   end

   // The published result set is loaded together with the final buffer write,
   // so it is already stable during the DONE cycle.
   always_comb begin
      sums_d = sums_q;
      if (state_q == S_DRAIN) begin
         sums_d = buf_d;
      end
   end

   // State, operand, pipeline and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         win_q      <= '0;
         mode_q     <= 1'b0;
         thr_q      <= '0;
         idx_q      <= '0;
         gx_q       <= '0;
         gy_q       <= '0;
         s1_valid_q <= 1'b0;
         s1_idx_q   <= '0;
         buf_q      <= '0;
         sums_q     <= '0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         mode_q     <= mode_d;
         thr_q      <= thr_d;
         idx_q      <= idx_d;
         gx_q       <= gx_d;
         gy_q       <= gy_d;
         s1_valid_q <= s1_valid_d;
         s1_idx_q   <= s1_idx_d;
         buf_q      <= buf_d;
         sums_q     <= sums_d;
      end
   end

   assign o_busy           = (state_q != S_IDLE);
   assign o_gradient_ready = (state_q == S_DONE);
   assign o_sums           = sums_q;

endmodule

// File: tb/tb_edge_detection_array_seq.sv
// Scoreboard bench for edge_detection_array_seq. One instance uses the default
// 5x5 window and a second one a 6x4 window with 10-bit pixels. Stimulus pushes
// the expected result set and ready cycle into a queue; per-instance monitors
// pop and compare whenever a ready pulse appears.
module tb_edge_detection_array_seq;

   logic         clk = 1'b0;
   logic         rst;

   logic         start1, mode1, busy1, ready1;
   logic [7:0]   thr1;
   logic [199:0] win1;
   logic [71:0]  sums1;

   logic         start2, mode2, busy2, ready2;
   logic [9:0]   thr2;
   logic [239:0] win2;
   logic [79:0]  sums2;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [79:0] sums;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   edge_detection_array_seq dut1 (
      .clk              (clk),
      .rst              (rst),
      .i_gradient_start (start1),
      .i_mode           (mode1),
      .i_threshold      (thr1),
      .i_window         (win1),
      .o_busy           (busy1),
      .o_gradient_ready (ready1),
      .o_sums           (sums1)
   );

   edge_detection_array_seq #(
      .PIX_W (10),
      .WIN_W (6),
      .WIN_H (4)
   ) dut2 (
      .clk              (clk),
      .rst              (rst),
      .i_gradient_start (start2),
      .i_mode           (mode2),
      .i_threshold      (thr2),
      .i_window         (win2),
      .o_busy           (busy2),
      .o_gradient_ready (ready2),
      .o_sums           (sums2)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter advanced on every active edge.
   always @(posedge clk) cyc++;

   // Hard time limit so the bench can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=still running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   // 5-column window: columns 0-1 hold lo, columns 2-4 hold hi.
   function automatic logic [199:0] colWin(input logic [7:0] lo, input logic [7:0] hi);
      logic [199:0] w;
      w = '0;
      for (int i = 24; i >= 0; i--) begin
         w = {w[191:0], ((i % 5) < 2) ? lo : hi};
      end
      return w;
   endfunction

   // Same three results repeated on each of the three output rows.
   function automatic logic [71:0] rowPat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      return {c, b, a, c, b, a, c, b, a};
   endfunction

   // Issue a start strobe in the current cycle, optionally expecting a ready pulse.
   task automatic applyStimulus(input int dut, input logic [239:0] w, input logic m,
                                input logic [9:0] t, input bit expectPulse,
                                input logic [79:0] expSums);
      exp_t e;
      e.sums = expSums;
      if (dut == 1) begin
         win1   = w[199:0];
         mode1  = m;
         thr1   = t[7:0];
         start1 = 1'b1;
         e.cyc  = cyc + 11;
         if (expectPulse) q1.push_back(e);
      end else begin
         win2   = w;
         mode2  = m;
         thr2   = t;
         start2 = 1'b1;
         e.cyc  = cyc + 10;
         if (expectPulse) q2.push_back(e);
      end
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      win1   = ~win1;
      mode1  = ~mode1;
      thr1   = ~thr1;
      win2   = ~win2;
      mode2  = ~mode2;
      thr2   = ~thr2;
   endtask

   // Monitor for the 5x5 instance: every ready pulse must match the oldest expectation.
   always @(negedge clk) begin : mon1
      exp_t e;
      if (ready1 === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL dut1_unexpected_ready actual=pulse@%0d required=none", cyc);
         end else begin
            e = q1.pop_front();
            checkOutput("dut1_sums", 80'(sums1), e.sums);
            checkOutput("dut1_ready_cycle", 80'(cyc), 80'(e.cyc));
         end
      end
   end

   // Monitor for the 6x4 instance.
   always @(negedge clk) begin : mon2
      exp_t e;
      if (ready2 === 1'b1) begin
         if (q2.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL dut2_unexpected_ready actual=pulse@%0d required=none", cyc);
         end else begin
            e = q2.pop_front();
            checkOutput("dut2_sums", sums2, e.sums);
            checkOutput("dut2_ready_cycle", 80'(cyc), 80'(e.cyc));
         end
      end
   end

   // Directed test sequence; all driving happens on falling edges.
   initial begin
      logic [239:0] w6;
      logic [79:0]  exp6;
      exp_t         e;

      rst    = 1'b1;
      start1 = 1'b0; mode1 = 1'b0; thr1 = '0; win1 = '0;
      start2 = 1'b0; mode2 = 1'b0; thr2 = '0; win2 = '0;
      repeat (3) @(negedge clk);

      checkOutput("reset_busy1",  80'(busy1),  80'(0));
      checkOutput("reset_ready1", 80'(ready1), 80'(0));
      checkOutput("reset_sums1",  80'(sums1),  80'(0));
      checkOutput("reset_busy2",  80'(busy2),  80'(0));
      checkOutput("reset_sums2",  sums2,       80'(0));
      rst = 1'b0;
      @(negedge clk);

      // Flat field: no gradients; busy spans cycles 1..11.
      $display("[TB] flat window");
      applyStimulus(1, 240'(colWin(8'd100, 8'd100)), 1'b0, 10'd0, 1'b1, 80'(0));
      for (int i = 1; i <= 11; i++) begin
         checkOutput("t1_busy", 80'(busy1), 80'(1));
         @(negedge clk);
      end
      checkOutput("t1_idle_after_done", 80'(busy1), 80'(0));

      // 0 -> 255 step: Gx = 1020 saturates to 255 on the two straddling windows.
      $display("[TB] hard step, saturated");
      applyStimulus(1, 240'(colWin(8'd0, 8'd255)), 1'b0, 10'd0, 1'b1,
                    80'(rowPat(8'd255, 8'd255, 8'd0)));
      repeat (11) @(negedge clk);
      repeat (3) @(negedge clk);
      checkOutput("t2_sums_hold", 80'(sums1), 80'(rowPat(8'd255, 8'd255, 8'd0)));

      // 10 -> 40 step: mag = 120, in magnitude mode and around the threshold.
      $display("[TB] soft step, both modes");
      applyStimulus(1, 240'(colWin(8'd10, 8'd40)), 1'b0, 10'd0, 1'b1,
                    80'(rowPat(8'd120, 8'd120, 8'd0)));
      repeat (11) @(negedge clk);
      applyStimulus(1, 240'(colWin(8'd10, 8'd40)), 1'b1, 10'd100, 1'b1,
                    80'(rowPat(8'd255, 8'd255, 8'd0)));
      repeat (11) @(negedge clk);
      applyStimulus(1, 240'(colWin(8'd10, 8'd40)), 1'b1, 10'd120, 1'b1,
                    80'(rowPat(8'd255, 8'd255, 8'd0)));
      repeat (11) @(negedge clk);
      applyStimulus(1, 240'(colWin(8'd10, 8'd40)), 1'b1, 10'd121, 1'b1, 80'(0));
      repeat (11) @(negedge clk);

      // A start while busy is ignored; a start right after DONE is taken.
      $display("[TB] start while busy");
      applyStimulus(1, 240'(colWin(8'd0, 8'd255)), 1'b0, 10'd0, 1'b1,
                    80'(rowPat(8'd255, 8'd255, 8'd0)));
      repeat (4) @(negedge clk);
      applyStimulus(1, 240'(colWin(8'd100, 8'd100)), 1'b1, 10'd0, 1'b0, 80'(0));
      repeat (6) @(negedge clk);
      applyStimulus(1, 240'(colWin(8'd10, 8'd40)), 1'b0, 10'd0, 1'b1,
                    80'(rowPat(8'd120, 8'd120, 8'd0)));
      repeat (11) @(negedge clk);

      // Reset in cycle 6 aborts the run; restart in cycle 8 completes in cycle 19.
      $display("[TB] abort by reset");
      applyStimulus(1, 240'(colWin(8'd0, 8'd255)), 1'b0, 10'd0, 1'b0, 80'(0));
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t5_busy_after_rst",  80'(busy1),  80'(0));
      checkOutput("t5_ready_after_rst", 80'(ready1), 80'(0));
      checkOutput("t5_sums_after_rst",  80'(sums1),  80'(0));
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(1, 240'(colWin(8'd10, 8'd40)), 1'b1, 10'd120, 1'b1,
                    80'(rowPat(8'd255, 8'd255, 8'd0)));
      repeat (11) @(negedge clk);

      // 6x4 window, single 1023 pixel at (1,1). It is the centre tap of k0 (no
      // Sobel weight), P3 of k1, P1 of k4 and P0 of k5; k2, k3, k6, k7 miss it.
      $display("[TB] 6x4 window, single bright pixel");
      w6         = '0;
      w6[79:70]  = 10'h3FF;
      exp6       = {10'h000, 10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h3FF, 10'h000};
      applyStimulus(2, w6, 1'b0, 10'd0, 1'b1, exp6);
      repeat (10) @(negedge clk);
      checkOutput("t6_idle_after_done", 80'(busy2), 80'(0));

      for (int i = 0; i < 50 && (q1.size() > 0 || q2.size() > 0); i++) begin
         @(negedge clk);
      end
      while (q1.size() > 0) begin
         e = q1.pop_front();
         checks++;
         failures++;
         $display("[TB] FAIL dut1_missing_ready actual=none required=pulse@%0d", e.cyc);
      end
      while (q2.size() > 0) begin
         e = q2.pop_front();
         checks++;
         failures++;
         $display("[TB] FAIL dut2_missing_ready actual=none required=pulse@%0d", e.cyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
